// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer: reads COUNT consecutive words of data RAM starting at
// BASE (address wraps modulo 2^ADDR_W) and streams them out on a
// valid/ready interface, one word every three cycles with no backpressure.
// Optional build macro MEM_DUMP_CHECKSUM_EN appends one extra beat carrying
// the modulo-2^DATA_W sum of all data words; that beat is the one flagged
// with out_last.
module mem_dump_streamer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int BASE   = 0,
    parameter int COUNT  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(COUNT - 1);

`ifdef MEM_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, REQ, LATCH, SEND, CSUM, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, LATCH, SEND, FIN} state_t;
`endif

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   index_reg, index_next;
    logic [DATA_W-1:0]   out_data_reg, out_data_next;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]   acc_reg, acc_next;
`endif

    // State, word index and output data register; reset aborts any dump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            index_reg    <= '0;
            out_data_reg <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            acc_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            index_reg    <= index_next;
            out_data_reg <= out_data_next;
`ifdef MEM_DUMP_CHECKSUM_EN
            acc_reg      <= acc_next;
`endif
        end
    end

    // Next-state logic: request, capture the RAM word, then hold it until accepted.
    always_comb begin
        state_next    = state_reg;
        index_next    = index_reg;
        out_data_next = out_data_reg;
`ifdef MEM_DUMP_CHECKSUM_EN
        acc_next      = acc_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    index_next = '0;
                    state_next = REQ;
`ifdef MEM_DUMP_CHECKSUM_EN
                    acc_next   = '0;
`endif
                end
            end
            REQ:   state_next = LATCH;
            LATCH: begin
                // RAM data is valid exactly one cycle after the read strobe.
                out_data_next = mem_rdata;
                state_next    = SEND;
            end
            SEND: begin
                if (out_ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                    acc_next = acc_reg + out_data_reg;
`endif
                    if (index_reg == LAST_IDX) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                        // The checksum beat reuses the output register.
                        out_data_next = acc_reg + out_data_reg;
                        state_next    = CSUM;
`else
                        state_next    = FIN;
`endif
                    end else begin
                        index_next = index_reg + 1'b1;
                        state_next = REQ;
                    end
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            CSUM: begin
                if (out_ready) state_next = FIN;
            end
`endif
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode directly from state so reset clears them immediately.
    always_comb begin
        busy      = (state_reg != IDLE);
        done      = (state_reg == FIN);
        mem_rd_en = (state_reg == REQ);
        mem_addr  = (state_reg == REQ) ? (BASE_ADDR + index_reg) : '0;
        out_data  = out_data_reg;
`ifdef MEM_DUMP_CHECKSUM_EN
        out_valid = (state_reg == SEND) || (state_reg == CSUM);
        out_last  = (state_reg == CSUM);
`else
        out_valid = (state_reg == SEND);
        out_last  = (state_reg == SEND) && (index_reg == LAST_IDX);
`endif
    end

endmodule

// File: tb/tb_mem_dump_streamer.sv
// Testbench for mem_dump_streamer: random RAM contents and random
// backpressure, checked against a reference list of expected addresses and
// beats built directly from BASE/COUNT and the RAM image.
module tb_mem_dump_streamer;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int BASE  = 253;
    localparam int COUNT = 6;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int NB = COUNT + 1;
`else
    localparam int NB = COUNT;
`endif

    logic          clk = 0;
    logic          rst = 0;
    logic          start = 0;
    logic          busy, done, mem_rd_en, out_valid, out_last;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] out_data;
    logic          out_ready = 0;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    mem_dump_streamer #(.ADDR_W(AW), .DATA_W(DW), .BASE(BASE), .COUNT(COUNT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model on the secondary port.
    always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_ram();
        for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
    endtask

    // One complete dump; abort_beat >= 0 resets the DUT while that beat is offered.
    task automatic run_dump(input bit rand_ready, input bit busy_start,
                            input bit fin_start, input int abort_beat);
        logic [DW-1:0] exp_q[$];
        logic [AW-1:0] addr_q[$];
        logic [DW-1:0] sum;
        logic [AW-1:0] a;
        int  beat, rd, dones, last_x, first_v, stall_cnt, c;
        bit  prev_stall, finished, aborted;
        logic [DW-1:0] prev_d;
        logic          prev_l;

        sum = '0;
        for (int i = 0; i < COUNT; i++) begin
            a = AW'(BASE + i);
            addr_q.push_back(a);
            exp_q.push_back(ram[a]);
            sum = sum + ram[a];
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
        beat = 0; rd = 0; dones = 0; last_x = -1; first_v = -1; stall_cnt = 0;
        prev_stall = 0; finished = 0; aborted = 0; prev_d = '0; prev_l = 0;

        @(negedge clk);
        c = 0;
        start = 1;
        out_ready = 1;
        for (int k = 0; k < 400 && !finished; k++) begin
            @(negedge clk);
            c++;
            start = 0;
            if (dones > 0 && !done) begin
                check(fin_start ? "fin_start_ignored" : "idle_after_done", busy, 0);
                finished = 1;
                break;
            end
            if (mem_rd_en) begin
                if (rd < COUNT) check("rd_addr", mem_addr, addr_q[rd]);
                else            check("rd_extra", rd, COUNT - 1);
                check("rd_outside_req", out_valid, 0);
                rd++;
            end
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_d);
                check("hold_last", out_last, prev_l);
            end
            if (out_valid) begin
                if (first_v < 0) begin
                    first_v = c;
                    check("first_latency", c, 3);
                end
                if (beat < NB) begin
                    check("data", out_data, exp_q[beat]);
                    check("last", out_last, beat == NB - 1);
                end else begin
                    check("extra_beat", beat, NB - 1);
                end
            end
            if (done) begin
                dones++;
                check("done_latency", c, last_x + 1);
                if (fin_start) start = 1;
            end
            if (abort_beat >= 0 && beat == abort_beat && out_valid) begin
                #2 rst = 0;
                #1;
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_rd_en", mem_rd_en, 0);
                check("abort_last", out_last, 0);
                @(negedge clk);
                rst = 1;
                @(negedge clk);
                check("abort_no_done", done, 0);
                check("abort_idle", busy, 0);
                aborted = 1;
                finished = 1;
                break;
            end
            if (busy_start && beat == 2 && out_valid) start = 1;
            if (rand_ready) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else if (beat == 1 && out_valid && stall_cnt < 5) begin
                out_ready = 0;
                stall_cnt++;
            end else begin
                out_ready = 1;
            end
            if (out_valid && out_ready) begin
                $display("beat %0d data=%08h last=%0b cycle=%0d", beat, out_data, out_last, c);
                if (!rand_ready && beat >= 2 && beat < COUNT) check("beat_spacing", c - last_x, 3);
                last_x = c;
                beat++;
                prev_stall = 0;
            end else begin
                prev_stall = out_valid;
                prev_d = out_data;
                prev_l = out_last;
            end
        end
        out_ready = 0;
        start = 0;
        if (!finished) check("timeout", 0, 1);
        if (!aborted) begin
            check("beat_count", beat, NB);
            check("rd_count", rd, COUNT);
            check("done_count", dones, 1);
        end
    endtask

    initial begin
        fill_ram();
        // Reset state while rst is held low.
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        rst = 1;
        @(negedge clk);
        out_ready = 1;
        @(negedge clk);
        check("ready_no_effect", out_valid, 0);
        out_ready = 0;

        run_dump(0, 0, 0, -1);   // full throughput plus a 5-cycle stall on beat 1
        run_dump(0, 1, 1, -1);   // start during beat 2 and during the done pulse
        run_dump(0, 0, 0, 2);    // reset while beat 2 is offered
        run_dump(0, 0, 0, -1);   // dump restarts from BASE after the abort
        for (int r = 0; r < 4; r++) begin
            fill_ram();
            run_dump(1, r[0], r[1], -1);
        end
        // Checksum wrap case: FFFFFFFF + 2 + zeros = 1.
        ram[AW'(BASE)]     = 32'hFFFF_FFFF;
        ram[AW'(BASE + 1)] = 32'h0000_0002;
        for (int i = 2; i < COUNT; i++) ram[AW'(BASE + i)] = '0;
        run_dump(1, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
